// File: rtl/aes_stream_sequencer.sv
// Block-level front end for a byte-serial AES core: takes one 128-bit request,
// streams it to the core, gathers the 16 result bytes and hands the block back.
//   state   | meaning
//   IDLE    | ready for a request
//   START   | one-cycle core_start pulse, feed delay loaded
//   FEED    | feed delay, then bytes 0..15 on core_data
//   WAIT    | watchdog running, waiting for core_z_ready
//   COLLECT | skip offset, then capture bytes 0..15 from core_z
//   DONE    | result (or timeout) presented until accepted
module aes_stream_sequencer #(
  parameter int FEED_DELAY = 0,
  parameter int Z_OFFSET   = 1,
  parameter int TIMEOUT    = 400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  input  logic         in_mode,
  output logic         core_start,
  output logic [7:0]   core_data,
  output logic [127:0] core_key,
  output logic         core_mode,
  input  logic [7:0]   core_z,
  input  logic         core_z_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         out_mode,
  output logic         timeout_err,
  output logic         busy
);

  localparam int DW = (FEED_DELAY > 0) ? $clog2(FEED_DELAY + 1) : 1;
  localparam int SW = (Z_OFFSET > 1) ? $clog2(Z_OFFSET) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FEED, S_WAIT, S_COLLECT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   blk_q, blk_d;
  logic [127:0]   key_q, key_d;
  logic           mode_q, mode_d;
  logic [127:0]   res_q, res_d;
  logic           err_q, err_d;
  logic [3:0]     idx_q, idx_d;
  logic [DW-1:0]  dly_q, dly_d;
  logic [SW-1:0]  skip_q, skip_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [7:0]     feed_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      dly_q   <= '0;
      skip_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      skip_q  <= skip_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    key_d       = key_q;
    mode_d      = mode_q;
    res_d       = res_q;
    err_d       = err_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    skip_d      = skip_q;
    wd_d        = wd_q;
    in_ready    = 1'b0;
    core_start  = 1'b0;
    core_data   = 8'h00;
    out_valid   = 1'b0;
    out_block   = '0;
    out_mode    = 1'b0;
    timeout_err = 1'b0;

    feed_byte = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (idx_q == 4'(k)) feed_byte = blk_q[127-8*k -: 8];
    end

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_block;
          key_d   = in_key;
          mode_d  = in_mode;
          res_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        dly_d      = DW'(FEED_DELAY);
        state_d    = S_FEED;
      end
      S_FEED: begin
        if (dly_q != '0) begin
          dly_d = dly_q - DW'(1);
        end else begin
          core_data = feed_byte;
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            wd_d    = WW'(TIMEOUT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // a strobe on the final watchdog cycle still wins over the timeout
        if (core_z_ready) begin
          skip_d  = SW'(Z_OFFSET - 1);
          idx_d   = '0;
          state_d = S_COLLECT;
        end else if (wd_q == WW'(1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q - WW'(1);
        end
      end
      S_COLLECT: begin
        if (skip_q != '0) begin
          skip_d = skip_q - SW'(1);
        end else begin
          for (int k = 0; k < 16; k++) begin
            if (idx_q == 4'(k)) res_d[127-8*k -: 8] = core_z;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid   = 1'b1;
        out_block   = res_q;
        out_mode    = mode_q;
        timeout_err = err_q;
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_key  = key_q;
  assign core_mode = mode_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Bench for aes_stream_sequencer: instance A (FEED_DELAY 0, Z_OFFSET 1, TIMEOUT 8)
// runs against a behavioural core; instance B (FEED_DELAY 3, Z_OFFSET 4) is scripted.
module tb_aes_stream_sequencer;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT       = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic         rst;
  logic         a_in_valid, a_in_ready, a_in_mode, a_core_start, a_core_mode, a_core_z_ready;
  logic         a_out_valid, a_out_ready, a_out_mode, a_timeout_err, a_busy;
  logic [127:0] a_in_block, a_in_key, a_core_key, a_out_block;
  logic [7:0]   a_core_data, a_core_z;
  logic         b_in_valid, b_in_ready, b_in_mode, b_core_start, b_core_mode, b_core_z_ready;
  logic         b_out_valid, b_out_ready, b_out_mode, b_timeout_err, b_busy;
  logic [127:0] b_in_block, b_in_key, b_core_key, b_out_block;
  logic [7:0]   b_core_data, b_core_z;

  aes_stream_sequencer #(.FEED_DELAY(0), .Z_OFFSET(1), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_block(a_in_block), .in_key(a_in_key), .in_mode(a_in_mode),
    .core_start(a_core_start), .core_data(a_core_data), .core_key(a_core_key),
    .core_mode(a_core_mode), .core_z(a_core_z), .core_z_ready(a_core_z_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block),
    .out_mode(a_out_mode), .timeout_err(a_timeout_err), .busy(a_busy)
  );

  aes_stream_sequencer #(.FEED_DELAY(3), .Z_OFFSET(4), .TIMEOUT(400)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_block(b_in_block), .in_key(b_in_key), .in_mode(b_in_mode),
    .core_start(b_core_start), .core_data(b_core_data), .core_key(b_core_key),
    .core_mode(b_core_mode), .core_z(b_core_z), .core_z_ready(b_core_z_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block),
    .out_mode(b_out_mode), .timeout_err(b_timeout_err), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
    return v[127-8*k -: 8];
  endfunction

  // Stand-in for the cipher: real FIPS-197 answers for the known vector,
  // an arbitrary but deterministic mix for anything else.
  function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [127:0] key,
                                           input logic mode);
    if (!mode && blk == PT && key == FIPS_KEY) return CT;
    if (mode && blk == CT && key == FIPS_KEY) return PT;
    return blk ^ key ^ {16{(mode ? 8'h5a : 8'ha5)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic         mode;
    logic         err;
    logic [127:0] blk;
  } exp_t;
  exp_t sb_q[$];

  logic         exp_mode_m = 1'b0;
  logic [127:0] exp_key_m  = '0;
  int           hold_bad   = 0;
  int           n_start    = 0;
  logic         core_en    = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (a_core_start) n_start++;
    if (a_busy && (a_core_mode !== exp_mode_m || a_core_key !== exp_key_m)) hold_bad++;
    if (rst && a_out_valid && a_out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", a_out_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("out_block", a_out_block, e.blk);
        check("out_mode", a_out_mode, e.mode);
        check("timeout_err", a_timeout_err, e.err);
      end
    end
  end

  // Behavioural core for instance A: gathers the fed bytes, strobes 3 cycles later.
  initial begin : core_model
    logic [127:0] buf_v, res_v, key_v;
    logic         mode_v, aborted;
    a_core_z       = 8'h00;
    a_core_z_ready = 1'b0;
    forever begin
      tick();
      if (a_core_start && core_en) begin
        key_v   = a_core_key;
        mode_v  = a_core_mode;
        aborted = 1'b0;
        buf_v   = '0;
        for (int k = 0; k < 16; k++) begin
          tick();
          buf_v[127-8*k -: 8] = a_core_data;
          if (!rst) aborted = 1'b1;
        end
        if (!aborted) begin
          res_v = core_fn(buf_v, key_v, mode_v);
          repeat (3) tick();
          a_core_z_ready = 1'b1;
          for (int k = 0; k < 16; k++) begin
            tick();
            a_core_z_ready = 1'b0;
            a_core_z       = byte_of(res_v, k);
          end
          tick();
          a_core_z = 8'h00;
        end
      end
    end
  end

  task automatic issue(input logic [127:0] blk, input logic mode, input logic push_sb,
                       input logic exp_err);
    exp_t e;
    a_in_block = blk;
    a_in_key   = FIPS_KEY;
    a_in_mode  = mode;
    a_in_valid = 1'b1;
    exp_mode_m = mode;
    exp_key_m  = FIPS_KEY;
    if (push_sb) begin
      e.mode = mode;
      e.err  = exp_err;
      e.blk  = exp_err ? 128'h0 : core_fn(blk, FIPS_KEY, mode);
      sb_q.push_back(e);
    end
    tick();
    a_in_valid = 1'b0;
    a_in_block = ~blk;
    a_in_key   = ~FIPS_KEY;
    a_in_mode  = ~mode;
  endtask

  task automatic check_feed(input logic [127:0] blk);
    check("core_start_c1", a_core_start, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("core_data_b%0d", k), a_core_data, byte_of(blk, k));
    end
    tick();
    check("core_data_after_feed", a_core_data, 8'h00);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!a_out_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check("out_valid_seen", a_out_valid, 1'b1);
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    int           cyc, s0, bp_bad;
    logic [127:0] blk1, blk2, rb;
    exp_t         e;
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_block = '0; a_in_key = '0; a_in_mode = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_block = '0; b_in_key = '0; b_in_mode = 1'b0; b_out_ready = 1'b1;
    b_core_z = 8'h00; b_core_z_ready = 1'b0;
    repeat (2) tick();

    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_ctrl", {a_core_start, a_core_data, a_out_valid, a_out_mode, a_timeout_err,
                       a_busy, a_core_mode}, '0);
    check("rst_out_block", a_out_block, '0);
    check("rst_core_key", a_core_key, '0);
    rst = 1'b1;
    tick();

    // FIPS-197 encrypt
    s0 = n_start; hold_bad = 0;
    issue(PT, 1'b0, 1'b1, 1'b0);
    check_feed(PT);
    wait_done(60, cyc);
    tick();
    check("enc_start_count", n_start - s0, 1);
    check("enc_key_mode_held", hold_bad, 0);

    // FIPS-197 decrypt
    s0 = n_start; hold_bad = 0;
    issue(CT, 1'b1, 1'b1, 1'b0);
    check_feed(CT);
    wait_done(60, cyc);
    check("dec_core_mode", a_core_mode, 1'b1);
    tick();
    check("dec_start_count", n_start - s0, 1);
    check("dec_key_mode_held", hold_bad, 0);

    // backpressure with a second request waiting
    blk1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    blk2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    a_out_ready = 1'b0; s0 = n_start; hold_bad = 0;
    issue(blk1, 1'b0, 1'b1, 1'b0);
    wait_done(60, cyc);
    a_in_valid = 1'b1; a_in_block = blk2; a_in_key = FIPS_KEY; a_in_mode = 1'b0;
    bp_bad = 0;
    repeat (20) begin
      tick();
      if (a_out_block !== core_fn(blk1, FIPS_KEY, 1'b0) || a_in_ready || !a_out_valid) bp_bad++;
    end
    check("bp_hold", bp_bad, 0);
    check("bp_start_count", n_start - s0, 1);
    e.mode = 1'b0; e.err = 1'b0; e.blk = core_fn(blk2, FIPS_KEY, 1'b0);
    sb_q.push_back(e);
    a_out_ready = 1'b1;
    tick();
    check("bp_in_ready_after_hs", a_in_ready, 1'b1);
    check("bp_no_bypass", a_core_start, 1'b0);
    tick();
    a_in_valid = 1'b0;
    check("bp_second_start", a_core_start, 1'b1);
    wait_done(60, cyc);
    tick();
    check("bp_key_mode_held", hold_bad, 0);

    // watchdog: core stays silent, WAIT entered in cycle 18, timeout in cycle 26
    core_en = 1'b0;
    issue(PT, 1'b0, 1'b1, 1'b1);
    wait_done(60, cyc);
    check("wd_latency", cyc, 25);
    tick();
    core_en = 1'b1;

    // reset during byte 7 of the feed
    issue(PT, 1'b0, 1'b0, 1'b0);
    repeat (8) tick();
    check("feed_b7_before_rst", a_core_data, 8'h77);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_in_ready", a_in_ready, 1'b1);
    check("rst_mid_core_data", a_core_data, 8'h00);
    check("rst_mid_out_valid", a_out_valid, 1'b0);
    check("rst_mid_busy", a_busy, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    s0 = n_start;
    issue(PT, 1'b0, 1'b1, 1'b0);
    check_feed(PT);
    wait_done(60, cyc);
    tick();
    check("post_rst_start_count", n_start - s0, 1);
    check("sb_drained", sb_q.size(), 0);

    // instance B: FEED_DELAY 3, Z_OFFSET 4, spurious strobe during the delay
    blk1 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    rb   = 128'ha1b2c3d4_e5f60718_293a4b5c_6d7e8f90;
    b_in_block = blk1; b_in_key = FIPS_KEY; b_in_mode = 1'b1; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0; b_in_block = '0; b_in_mode = 1'b0;
    check("b_start_c1", b_core_start, 1'b1);
    tick();
    check("b_delay_c2", b_core_data, 8'h00);
    tick();
    b_core_z_ready = 1'b1;
    check("b_delay_c3", b_core_data, 8'h00);
    tick();
    b_core_z_ready = 1'b0;
    check("b_delay_c4", b_core_data, 8'h00);
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b_core_data_b%0d", k), b_core_data, byte_of(blk1, k));
      tick();
    end
    check("b_core_data_after_feed", b_core_data, 8'h00);
    tick(); tick();
    b_core_z_ready = 1'b1; b_core_z = 8'hee;
    tick();
    b_core_z_ready = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 16; k++) begin
      b_core_z = byte_of(rb, k);
      if (k == 15) check("b_not_early", b_out_valid, 1'b0);
      tick();
    end
    b_core_z = 8'hee;
    check("b_out_valid", b_out_valid, 1'b1);
    check("b_out_block", b_out_block, rb);
    check("b_out_mode", b_out_mode, 1'b1);
    check("b_timeout_err", b_timeout_err, 1'b0);
    check("b_core_key", b_core_key, FIPS_KEY);
    tick();
    check("b_idle_after_hs", {b_in_ready, b_busy}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_stream_sequencer.md
Name: aes_stream_sequencer

Overview:
Sequences one byte-serial AES encrypt/decrypt core for a 128-bit block-level host.
- Accepts a block, key and mode on a valid/ready handshake.
- Issues the core start pulse and feeds the block as 16 bytes on consecutive cycles.
- Collects 16 result bytes after the core's ready strobe and returns the assembled block on a valid/ready output handshake.
- Includes a watchdog that ends the transaction with an error flag if the core never responds.

Parameters:
FEED_DELAY, 0, idle cycles between the core_start cycle and the first fed byte
Z_OFFSET, 1, cycles from core_z_ready sampled high to the first result byte on core_z
TIMEOUT, 400, maximum WAIT cycles before the transaction is aborted (at least 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  host request valid
in_ready  out  1  sequencer can accept a request
in_block  in  128  input block; byte k = in_block[127-8k -: 8]
in_key  in  128  cipher key
in_mode  in  1  0 = encrypt, 1 = decrypt
core_start  out  1  one-cycle start pulse to the core
core_data  out  8  byte stream to the core
core_key  out  128  key held stable for the whole transaction
core_mode  out  1  mode held stable for the whole transaction
core_z  in  8  core result byte stream
core_z_ready  in  1  core result strobe
out_valid  out  1  result valid
out_ready  in  1  host accepts result
out_block  out  128  result block; byte k = out_block[127-8k -: 8]
out_mode  out  1  mode of the returned block
timeout_err  out  1  result aborted by watchdog; qualified by out_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst = 0, asynchronous): state goes to IDLE. Every output is 0 except in_ready, which is 1. All internal counters and registers are cleared. Reset mid-transaction discards the transaction with no output handshake.
- States: IDLE, START, FEED, WAIT, COLLECT, DONE.
- IDLE: in_ready = 1. When in_valid is high, capture in_block, in_key and in_mode into registers, then go to START. core_key and core_mode come from these registers.
- START: core_start = 1 for exactly this cycle. Load the delay counter with FEED_DELAY, then go to FEED.
- FEED: while the delay counter is non-zero it decrements and core_data = 0. Afterwards, byte k (k = 0..15) is driven on core_data for one cycle each, in order. Accept cycle = 0, so byte k appears in cycle 2 + FEED_DELAY + k. After byte 15, go to WAIT with core_data = 0.
- WAIT: the watchdog counts cycles. If core_z_ready is sampled high, load the skip counter with Z_OFFSET - 1 and go to COLLECT. If the watchdog reaches TIMEOUT first, set timeout_err = 1, leave out_block = 0 and go to DONE.
- COLLECT: once the skip count has expired, capture core_z into byte k of out_block for k = 0..15 on consecutive cycles. The first captured byte is the core_z value Z_OFFSET cycles after the strobe cycle. After byte 15, go to DONE.
- DONE: out_valid = 1. out_block, out_mode and timeout_err hold stable until out_valid and out_ready are both high. On that handshake, clear out_valid and timeout_err, then go to IDLE. The next request is accepted no earlier than the following cycle; there is no bypass.
- core_z_ready is ignored outside WAIT. A strobe arriving during FEED is not remembered.
- in_valid is ignored outside IDLE. in_block, in_key and in_mode are sampled only on acceptance; later changes have no effect.
- Counter widths: byte index 4 bits, wrapping 15→0 at the state change. Watchdog width is $clog2(TIMEOUT+1). No counter overflows in any state.
- Latency without timeout: out_valid rises 1 cycle after the last collected byte.

Test Plan:
- FIPS-197 encrypt, behavioural core model, FEED_DELAY = 0, Z_OFFSET = 1. Key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, mode 0. Required: core_data bytes 00, 11, … ff in cycles 2–17, one core_start pulse in cycle 1, out_block = 69c4e0d86a7b0430d8cdb78070b4c55a, timeout_err = 0.
- Decrypt the same key with block 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1. Required: out_block = 00112233445566778899aabbccddeeff, out_mode = 1, core_mode held at 1 throughout.
- Backpressure: hold out_ready = 0 for 20 cycles in DONE while in_valid = 1. Required: out_block stable, in_ready = 0, no second core_start; the second request is accepted the cycle after the handshake.
- Watchdog with TIMEOUT = 8 and a core that never strobes. Required: out_valid with timeout_err = 1 and out_block = 0 exactly 8 cycles after entering WAIT.
- Reset mid-FEED: drop rst at byte 7. Required: immediate IDLE, in_ready = 1, core_data = 0, out_valid = 0. A fresh FIPS-197 request after reset completes correctly.
- Parameter sweep FEED_DELAY = 3, Z_OFFSET = 4: a spurious core_z_ready during FEED is ignored. Required: the first byte appears in cycle 5, and capture starts 4 cycles after the real strobe.
